// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: PC-select command encodings shared with the control unit,
// fetch FSM state encodings and default widths.
package instr_fetch_unit_pkg;
   localparam int IFU_IW = 20;
   localparam int IFU_AW = 6;
   typedef enum logic [1:0] {PC_HOLD = 2'b00, PC_INC = 2'b01, PC_JMP = 2'b10, PC_HALT = 2'b11} pc_sel_e;
   typedef enum logic [1:0] {IFU_IDLE = 2'b00, IFU_WAIT = 2'b01, IFU_HALT = 2'b10} ifu_state_e;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// instr_fetch_unit_fifo: synchronous prefetch FIFO of {instr, pc} with flush.
// Pop on empty is ignored; flush overrides push and pop.
module instr_fetch_unit_fifo #(
   parameter int IW = 20,
   parameter int AW = 6,
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [IW-1:0] push_instr,
   input  logic [AW-1:0] push_pc,
   output logic [IW-1:0] head_instr,
   output logic [AW-1:0] head_pc,
   output logic [CW-1:0] count
);
   logic [IW-1:0] instr_mem [DEPTH];
   logic [AW-1:0] pc_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic do_pop;
   assign do_pop = pop && count != '0;
   always_ff @(posedge clk)
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (push) begin
         instr_mem[wr_ptr] <= push_instr;
         pc_mem[wr_ptr] <= push_pc;
      end
   assign head_instr = instr_mem[rd_ptr];
   assign head_pc = pc_mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from imem over req/ack with one request
// outstanding, and buffers responses in a prefetch FIFO for the control unit.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int IW = IFU_IW,
   parameter int AW = IFU_AW,
   parameter int DEPTH = 2,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pc_strobe,
   input  logic [1:0]    pc_sel,
   input  logic [AW-1:0] gamma,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   output logic [AW-1:0] head_pc,
   output logic          halted,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata
);
   localparam int CW = $clog2(DEPTH + 1);
   ifu_state_e state, state_nxt;
   logic [AW-1:0] fetch_pc, fifo_pc;
   logic [IW-1:0] fifo_instr;
   logic [CW-1:0] count;
   logic drop, cmd, jmp, halt_cmd, pop, ack, push, issue, empty, full;
   assign cmd = pc_strobe && !halted;
   assign jmp = cmd && pc_sel == PC_JMP;
   assign halt_cmd = cmd && pc_sel == PC_HALT;
   assign pop = cmd && pc_sel == PC_INC;
   assign ack = state == IFU_WAIT && imem_ack;
   // a response landing with a jump or halt, or after a jump, is stale
   assign push = ack && !drop && !jmp && !halt_cmd && !halted;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   // a free slot is reserved at issue, so an ack never finds the FIFO full
   assign issue = !halted && !halt_cmd && !jmp && !full;
   always_ff @(posedge clk)
      if (rst) state <= IFU_IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = (state == IFU_IDLE) ? ((halted || halt_cmd) ? IFU_HALT : issue ? IFU_WAIT : IFU_IDLE) :
                  (state == IFU_WAIT && imem_ack) ? ((halted || halt_cmd) ? IFU_HALT : IFU_IDLE) : state;
   always_ff @(posedge clk)
      if (rst) begin
         fetch_pc <= RESET_PC;
         imem_addr <= '0;
         drop <= 1'b0;
         halted <= 1'b0;
      end else begin
         if (jmp) fetch_pc <= gamma;
         else if (push) fetch_pc <= fetch_pc + AW'(1);
         if (state == IFU_IDLE && issue) imem_addr <= fetch_pc;
         drop <= ack ? 1'b0 : (jmp && state == IFU_WAIT) ? 1'b1 : drop;
         if (halt_cmd) halted <= 1'b1;
      end
   always_comb begin
      imem_req = state == IFU_WAIT;
      instr_valid = !empty && !halted;
      instr = instr_valid ? fifo_instr : '0;
      head_pc = instr_valid ? fifo_pc : '0;
   end
   instr_fetch_unit_fifo #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) ifu_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .flush(jmp),
      .push_instr(imem_rdata),
      .push_pc(imem_addr),
      .head_instr(fifo_instr),
      .head_pc(fifo_pc),
      .count(count)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a latency-programmable imem model and
// scoreboard queues of expected request addresses and expected {pc, instr} heads.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;
   localparam int IW = 20;
   localparam int AW = 6;
   logic clk = 1'b0, rst = 1'b1, pc_strobe = 1'b0;
   logic [1:0] pc_sel = 2'b00;
   logic [AW-1:0] gamma = '0;
   logic [IW-1:0] instr, imem_rdata;
   logic [AW-1:0] head_pc, imem_addr;
   logic instr_valid, halted, imem_req, imem_ack;
   logic mem_blk = 1'b0, force_ack = 1'b0;
   int mem_lat = 0, lat_cnt = 0;
   int n_tests = 0, n_fail = 0;
   logic [AW-1:0] req_log[$], exp_addr[$];
   logic [AW+IW-1:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mem_data(logic [AW-1:0] a);
      return (a == 6'd0) ? 20'h42005 : (a == 6'd1) ? 20'h51200 : (20'hA0000 | 20'(a));
   endfunction

   function automatic logic [AW+IW-1:0] ent(logic [AW-1:0] a);
      return {a, mem_data(a)};
   endfunction

   assign imem_ack = force_ack || (imem_req && !mem_blk && lat_cnt >= mem_lat);
   assign imem_rdata = mem_data(imem_addr);

   always @(posedge clk) begin
      lat_cnt <= (imem_req && !imem_ack) ? lat_cnt + 1 : 0;
      if (imem_req && imem_ack) req_log.push_back(imem_addr);
   end

   instr_fetch_unit dut (
      .clk(clk),
      .rst(rst),
      .pc_strobe(pc_strobe),
      .pc_sel(pc_sel),
      .gamma(gamma),
      .instr(instr),
      .instr_valid(instr_valid),
      .head_pc(head_pc),
      .halted(halted),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [1:0] sel, input logic [AW-1:0] g = '0);
      pc_strobe = 1'b1;
      pc_sel = sel;
      gamma = g;
      tick();
      pc_strobe = 1'b0;
      pc_sel = PC_HOLD;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      req_log.delete();
      exp_q.delete();
      exp_addr.delete();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(instr_valid), 32'd1);
   endtask

   task automatic pop_check(input string tag);
      logic [AW+IW-1:0] e;
      wait_valid({tag, "_valid"});
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk({tag, "_pc"}, 32'(head_pc), 32'(e[AW+IW-1:IW]));
      chk({tag, "_instr"}, 32'(instr), 32'(e[IW-1:0]));
      strobe(PC_INC);
   endtask

   task automatic check_reqs(input string tag);
      logic [AW-1:0] e;
      while (exp_addr.size() != 0) begin
         e = exp_addr.pop_front();
         chk(tag, (req_log.size() != 0) ? 32'(req_log.pop_front()) : 32'hFFFF_FFFF, 32'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset state
      rst = 1'b1;
      tick(2);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(head_pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      rst = 1'b0;
      // 1: zero-wait fetch of addr 0 then 1
      tick();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr0", 32'(imem_addr), 32'd0);
      chk("t1_nvalid", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr", 32'(instr), 32'h42005);
      chk("t1_pc", 32'(head_pc), 32'd0);
      tick();
      chk("t1_req1", 32'(imem_req), 32'd1);
      chk("t1_addr1", 32'(imem_addr), 32'd1);
      // 2: FIFO fills after two requests, single pop releases one more
      exp_addr.push_back(6'd0);
      exp_addr.push_back(6'd1);
      tick(9);
      chk("t2_idle", 32'(imem_req), 32'd0);
      check_reqs("t2_addr");
      chk("t2_nreq", 32'(req_log.size()), 32'd0);
      exp_q.push_back(ent(6'd0));
      exp_q.push_back(ent(6'd1));
      pop_check("t2_pop0");
      tick();
      chk("t2_req2", 32'(imem_req), 32'd1);
      chk("t2_addr2", 32'(imem_addr), 32'd2);
      // 3: jump while addr 1 is in flight on a slow memory
      mem_lat = 2;
      do_reset();
      exp_addr.push_back(6'd0);
      exp_addr.push_back(6'd1);
      exp_addr.push_back(6'h20);
      n = 0;
      while (!(imem_req && imem_addr == 6'd1) && n < 40) begin
         tick();
         n++;
      end
      chk("t3_addr1_seen", 32'(imem_addr), 32'd1);
      strobe(PC_JMP, 6'h20);
      chk("t3_flush", 32'(instr_valid), 32'd0);
      chk("t3_hold_req", 32'(imem_req), 32'd1);
      chk("t3_hold_addr", 32'(imem_addr), 32'd1);
      exp_q.push_back(ent(6'h20));
      n = 0;
      while (!(imem_req && imem_addr != 6'd1) && n < 40) begin
         tick();
         n++;
      end
      chk("t3_next_addr", 32'(imem_addr), 32'h20);
      pop_check("t3_pop");
      check_reqs("t3_addr");
      // 4: jump to 63 and pop continuously across the wrap
      mem_lat = 0;
      do_reset();
      strobe(PC_JMP, 6'd63);
      exp_addr.push_back(6'd63);
      exp_addr.push_back(6'd0);
      exp_addr.push_back(6'd1);
      exp_q.push_back(ent(6'd63));
      exp_q.push_back(ent(6'd0));
      exp_q.push_back(ent(6'd1));
      pop_check("t4_pop63");
      pop_check("t4_pop0");
      pop_check("t4_pop1");
      check_reqs("t4_addr");
      // 5: halt with an entry buffered
      wait_valid("t5_valid");
      strobe(PC_HALT);
      chk("t5_nvalid", 32'(instr_valid), 32'd0);
      chk("t5_halted", 32'(halted), 32'd1);
      n = 0;
      while (imem_req && n < 20) begin
         tick();
         n++;
      end
      req_log.delete();
      strobe(PC_INC);
      strobe(PC_JMP, 6'd5);
      tick(10);
      chk("t5_noreq", 32'(req_log.size()), 32'd0);
      chk("t5_req", 32'(imem_req), 32'd0);
      chk("t5_sticky", 32'(halted), 32'd1);
      chk("t5_valid_low", 32'(instr_valid), 32'd0);
      chk("t5_instr0", 32'(instr), 32'd0);
      chk("t5_pc0", 32'(head_pc), 32'd0);
      // 6: reset during an outstanding request, late ack afterwards
      mem_blk = 1'b1;
      do_reset();
      chk("t6_unhalted", 32'(halted), 32'd0);
      n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      chk("t6_req_seen", 32'(imem_req), 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_req_drop", 32'(imem_req), 32'd0);
      rst = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      chk("t6_refetch_req", 32'(imem_req), 32'd1);
      chk("t6_refetch_addr", 32'(imem_addr), 32'd0);
      chk("t6_late_ignored", 32'(instr_valid), 32'd0);
      chk("t6_nolog", 32'(req_log.size()), 32'd0);
      mem_blk = 1'b0;
      exp_addr.push_back(6'd0);
      exp_q.push_back(ent(6'd0));
      pop_check("t6_pop");
      check_reqs("t6_addr");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
